instr_decode_stage: RTL and testbench

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

---
 rtl/decode_pkg.sv | 33 +++
 rtl/imm_extend.sv | 17 +
 rtl/instr_decode_stage.sv | 118 +++++++++++
 tb/tb_instr_decode_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode map, stage states and opcode classification helpers.
package decode_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_ADDI  = 4'h5,
    OP_JMP   = 4'h6,
    OP_BRZ   = 4'h7,
    OP_AND   = 4'h8,
    OP_OR    = 4'h9,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // Opcodes whose immediate is a signed offset/addend.
  function automatic logic needs_sign_ext(logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_BRZ);
  endfunction

  function automatic logic is_legal(logic [3:0] op);
    return op inside {OP_NOP, OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_ADDI,
                      OP_JMP, OP_BRZ, OP_AND, OP_OR, OP_HALT};
  endfunction

endpackage

// File: rtl/imm_extend.sv
// Combinational sign/zero extension of the instruction immediate field to XLEN bits.
module imm_extend #(
  parameter int IN_W = 12,
  parameter int XLEN = 16
) (
  input  logic [IN_W-1:0] value,
  input  logic            sign_ext,
  output logic [XLEN-1:0] ext
);

  // A size cast of a signed operand replicates its top bit.
  always_comb begin
    if (sign_ext) ext = XLEN'($signed(value));
    else          ext = XLEN'(value);
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Single-entry decode stage with valid/ready handshakes and a RUN/HALTED FSM.
// Define DECODE_ILLEGAL_TRAP_EN to flag illegal opcodes and halt on them.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int IW   = 16,
  parameter int OPW  = 4,
  parameter int REGW = 4,
  parameter int XLEN = 16,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt_program,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   ir,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  op_code,
  output logic [REGW-1:0] rd,
  output logic [REGW-1:0] rs,
  output logic [XLEN-1:0] imm,
  output logic            is_halt,
  output logic            illegal,
  output logic            halted,
  output logic [CNTW-1:0] instr_count
);

  localparam int FW = IW - OPW;

  state_e          state_q, state_d;
  logic [OPW-1:0]  dec_op_raw;
  logic [3:0]      op4;
  logic            dec_sext;
  logic [XLEN-1:0] ext_imm;
  logic [OPW-1:0]  dec_op;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            dec_trap;
  logic            accept;

  assign dec_op_raw = ir[IW-1 -: OPW];
  assign op4        = 4'(dec_op_raw);
  assign dec_sext   = needs_sign_ext(op4);

  imm_extend #(
    .IN_W (FW),
    .XLEN (XLEN)
  ) u_imm_extend (
    .value    (ir[FW-1:0]),
    .sign_ext (dec_sext),
    .ext      (ext_imm)
  );

  // Illegal opcodes either trap with a flag or decay to a plain NOP.
  always_comb begin
    dec_op      = dec_op_raw;
    dec_imm     = ext_imm;
    dec_illegal = 1'b0;
    dec_trap    = (op4 == OP_HALT);
`ifdef DECODE_ILLEGAL_TRAP_EN
    dec_illegal = !is_legal(op4);
    dec_trap    = dec_trap || dec_illegal;
`else
    if (!is_legal(op4)) begin
      dec_op  = '0;
      dec_imm = '0;
    end
`endif
  end

  assign in_ready = (!out_valid || out_ready) && (state_q == ST_RUN) && !halt_program;
  assign accept   = in_valid && in_ready;
  assign halted   = (state_q == ST_HALTED);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (accept && dec_trap) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
    endcase
    if (flush) state_d = ST_RUN;
  end

  // Everything freezes under halt_program; flush beats a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      out_valid   <= 1'b0;
      op_code     <= '0;
      rd          <= '0;
      rs          <= '0;
      imm         <= '0;
      is_halt     <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else if (!halt_program) begin
      state_q <= state_d;
      if (out_valid && out_ready) instr_count <= instr_count + CNTW'(1);
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        op_code   <= dec_op;
        rd        <= ir[FW-1 -: REGW];
        rs        <= ir[FW-REGW-1 -: REGW];
        imm       <= dec_imm;
        is_halt   <= (op4 == OP_HALT);
        illegal   <= dec_illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: directed scenarios plus randomized traffic.
// Honors DECODE_ILLEGAL_TRAP_EN in its reference model.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt_program;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ir;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  op_code;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [15:0] imm;
  logic        is_halt;
  logic        illegal;
  logic        halted;
  logic [15:0] instr_count;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .halt_program (halt_program),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ir           (ir),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .op_code      (op_code),
    .rd           (rd),
    .rs           (rs),
    .imm          (imm),
    .is_halt      (is_halt),
    .illegal      (illegal),
    .halted       (halted),
    .instr_count  (instr_count)
  );

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic        is_halt;
    logic        illegal;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          m_ov;
  bit          m_halted;
  logic [15:0] m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit opLegal(input int opc);
    return (opc <= 9) || (opc == 15);
  endfunction

  function automatic exp_t refDecode(input logic [15:0] instr);
    exp_t e;
    int   opc;
    int   field;
    opc       = int'(instr[15:12]);
    field     = int'(instr[11:0]);
    e.op      = 4'(opc);
    e.rd      = instr[11:8];
    e.rs      = instr[7:4];
    e.is_halt = (opc == 15);
    e.illegal = 1'b0;
    if ((opc == 5 || opc == 7) && field >= 2048) e.imm = 16'(field - 4096);
    else                                          e.imm = 16'(field);
    if (!opLegal(opc)) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      e.illegal = 1'b1;
`else
      e.op  = 4'd0;
      e.imm = 16'd0;
`endif
    end
    return e;
  endfunction

  function automatic bit refTraps(input logic [15:0] instr);
    int opc;
    opc = int'(instr[15:12]);
`ifdef DECODE_ILLEGAL_TRAP_EN
    return (opc == 15) || !opLegal(opc);
`else
    return (opc == 15);
`endif
  endfunction

  // Monitor: pops one expectation per newly presented output and checks it while held.
  bit   pending = 1'b0;
  bit   have_cur = 1'b0;
  exp_t cur;
  always @(posedge clk) begin
    bit xfer;
    bit fl;
    xfer = out_valid && out_ready && !halt_program;
    fl   = flush && !halt_program;
    #1;
    if (!rst_n || xfer || fl) pending = 1'b0;
    if (rst_n && out_valid) begin
      if (!pending) begin
        pending = 1'b1;
        if (sb_q.size() == 0) begin
          have_cur = 1'b0;
          check("unexpected_output", 32'(sb_q.size()), 32'd1);
        end else begin
          have_cur = 1'b1;
          cur = sb_q.pop_front();
        end
      end
      if (have_cur)
        check("decode_fields", {op_code, rd, rs, imm, is_halt, illegal},
              {cur.op, cur.rd, cur.rs, cur.imm, cur.is_halt, cur.illegal});
    end
  end

  task automatic checkOutput();
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("halted", 32'(halted), 32'(m_halted));
    check("instr_count", 32'(instr_count), 32'(m_count));
  endtask

  task automatic applyStimulus(input bit iv, input logic [15:0] instr, input bit ordy,
                               input bit hp, input bit fl, output bit consumed);
    bit exp_rdy;
    bit acc;
    in_valid     = iv;
    ir           = instr;
    out_ready    = ordy;
    halt_program = hp;
    flush        = fl;
    #1;
    exp_rdy = (!m_ov || ordy) && !m_halted && !hp;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    consumed = iv && exp_rdy;
    acc      = consumed && !fl;
    if (acc) sb_q.push_back(refDecode(instr));
    if (!hp) begin
      if (m_ov && ordy) m_count = m_count + 16'd1;
      if (fl) begin
        m_ov     = 1'b0;
        m_halted = 1'b0;
      end else if (acc) begin
        m_ov = 1'b1;
        if (refTraps(instr)) m_halted = 1'b1;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
    end
  endtask

  task automatic cycleStep(input bit iv, input logic [15:0] instr, input bit ordy,
                           input bit hp, input bit fl, output bit consumed);
    @(negedge clk);
    checkOutput();
    applyStimulus(iv, instr, ordy, hp, fl, consumed);
  endtask

  task automatic sendInstr(input logic [15:0] instr, input bit ordy);
    bit c;
    int n;
    c = 1'b0;
    n = 0;
    while (!c && n < 20) begin
      cycleStep(1'b1, instr, ordy, 1'b0, 1'b0, c);
      n++;
    end
    if (!c) check("send_timeout", 32'(c), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_count"}, 32'(instr_count), 32'd0);
    check({tag, "_fields"}, {op_code, rd, rs, imm, is_halt, illegal}, 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    sb_q.delete();
    m_ov         = 1'b0;
    m_halted     = 1'b0;
    m_count      = 16'd0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    halt_program = 1'b0;
    flush        = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          c;
    logic [15:0] cur_ir;
    int          hp_left;
    logic [15:0] stream[4];
    rst_n        = 1'b0;
    halt_program = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    ir           = 16'd0;
    m_ov         = 1'b0;
    m_halted     = 1'b0;
    m_count      = 16'd0;
    #1;
    checkResetValues("power_on");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] ADDI sign extension");
    sendInstr(16'h5AF3, 1'b1);
    cycleStep(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, c);
    check("addi_op", 32'(op_code), 32'h5);
    check("addi_rd_rs", 32'({rd, rs}), 32'hAF);
    check("addi_imm", 32'(imm), 32'hFAF3);

    $display("[TB] JMP held under backpressure");
    sendInstr(16'h6AF3, 1'b0);
    for (int i = 0; i < 3; i++) cycleStep(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, c);
    check("jmp_imm", 32'(imm), 32'h0AF3);
    check("jmp_count_frozen", 32'(instr_count), 32'd1);
    cycleStep(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, c);

    $display("[TB] HALT stream");
    stream = '{16'h1123, 16'h3456, 16'hF000, 16'h4789};
    for (int i = 0; i < 3; i++) sendInstr(stream[i], 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycleStep(1'b1, stream[3], 1'b1, 1'b0, 1'b0, c);
      check("halted_blocks_accept", 32'(c), 32'd0);
    end
    check("halt_presented", 32'(is_halt), 32'd1);
    check("halted_flag", 32'(halted), 32'd1);
    cycleStep(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, c);
    sendInstr(stream[3], 1'b1);

    $display("[TB] Illegal opcode");
    sendInstr(16'hB000, 1'b1);
    cycleStep(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, c);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("illegal_flag", 32'(illegal), 32'd1);
    check("illegal_halts", 32'(halted), 32'd1);
`else
    check("illegal_as_nop", 32'({op_code, illegal, halted}), 32'd0);
`endif
    cycleStep(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, c);

    $display("[TB] halt_program freeze in stream");
    for (int i = 0; i < 8; i++) begin
      c = 1'b0;
      cur_ir = 16'(16'h1000 * (i % 4 + 1) + i);
      for (int k = 0; k < 20 && !c; k++)
        cycleStep(1'b1, cur_ir, 1'b1, (i == 3 && k < 5), 1'b0, c);
    end
    cycleStep(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, c);

    $display("[TB] reset mid-stall, flush with accept");
    sendInstr(16'h9ABC, 1'b0);
    cycleStep(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, c);
    doReset();
    cycleStep(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, c);
    cycleStep(1'b1, 16'h3DEF, 1'b1, 1'b0, 1'b1, c);
    cycleStep(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, c);
    cycleStep(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, c);

    $display("[TB] randomized traffic");
    hp_left = 0;
    cur_ir  = 16'($urandom);
    for (int i = 0; i < 700; i++) begin
      bit hp;
      hp = 1'b0;
      if (hp_left > 0) begin
        hp = 1'b1;
        hp_left--;
      end else if ($urandom_range(0, 19) == 0) begin
        hp_left = $urandom_range(1, 5);
      end
      cycleStep(($urandom_range(0, 3) != 0), cur_ir, ($urandom_range(0, 2) != 0), hp,
                ($urandom_range(0, 15) == 0), c);
      if (c) cur_ir = 16'($urandom);
    end

    cycleStep(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, c);
    for (int i = 0; i < 3; i++) cycleStep(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, c);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
